final_subtraction: RTL and testbench

- Runtime-configurable pipelined carry-propagate subtractor computing out = in1 - in2, the difference counterpart of the team's pipelined final adder in the DSP datapath.
- Fully pipelined: one operand pair accepted per cycle, with latency equal to the configured pipe count (0..4).
- Unlike the adder, input skew and output de-skew registers keep every result bit aligned, and a valid/ready handshake tracks data in flight.
- The pipe configuration is only allowed to change once the pipeline has drained.

---
 rtl/final_subtraction.sv | 155 +++++++++++++++
 tb/tb_final_subtraction.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_subtraction.sv
// Runtime-configurable pipelined subtractor (out = in1 - in2) with skew/de-skew and valid tracking.
// Optional signed-overflow output enabled by FINAL_SUB_OVERFLOW_EN.
module final_subtraction #(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int PIPELINE_BITS    = 3,
  parameter int MAX_PIPES        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIPELINE_BITS-1:0] pipes,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in1,
  input  logic [WIDTH-1:0]         in2,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out,
  output logic                     borrow_out,
  output logic                     busy
`ifdef FINAL_SUB_OVERFLOW_EN
  ,
  output logic                     ovf
`endif
);

  localparam int SW   = PIPE_STAGE_WIDTH;
  localparam int NSEG = WIDTH / SW;
  localparam int PB   = PIPELINE_BITS;
  localparam logic [PB-1:0] MAXP = PB'(MAX_PIPES);

  typedef logic [SW-1:0] seg_t;

  // Group index of segment s for latency l (number of cuts at or below s)
  function automatic int grp(input int s, input int l);
    int g;
    g = 0;
    for (int k = 1; k <= MAX_PIPES; k++)
      if (k <= l && (k * NSEG) / (l + 1) <= s) g++;
    return g;
  endfunction

  logic [PB-1:0]    cfg;
  logic [PB-1:0]    want;
  logic             accept;
  logic [MAX_PIPES:1] vq;
  seg_t             sa_q [NSEG][MAX_PIPES];
  seg_t             sb_q [NSEG][MAX_PIPES];
  seg_t             rd_q [NSEG][MAX_PIPES];
  seg_t             rs   [NSEG];
  logic [NSEG-1:0]  co;
  logic [NSEG-1:0]  cr_q;
  logic [WIDTH-1:0] res;
  int               lat;

  assign want     = (pipes > MAXP) ? MAXP : pipes;
  assign in_ready = (want == cfg);
  assign accept   = in_valid & in_ready;
  assign lat      = int'(cfg);
  assign busy     = |vq;

  always_comb begin : datapath
    seg_t a;
    seg_t b;
    logic c;
    int   g;
    int   gp;
    c  = 1'b1;
    gp = 0;
    co = '0;
    for (int s = 0; s < NSEG; s++) begin
      g = grp(s, lat);
      a = in1[s*SW +: SW];
      b = in2[s*SW +: SW];
      for (int d = 1; d <= MAX_PIPES; d++)
        if (g == d) begin
          a = sa_q[s][d-1];
          b = sb_q[s][d-1];
        end
      // across a cut the carry comes from the previous cycle
      if (g != gp) c = cr_q[s];
      {c, rs[s]} = {1'b0, a} + {1'b0, ~b} + {{SW{1'b0}}, c};
      co[s] = c;
      gp = g;
    end
  end

  always_comb begin : deskew
    int dl;
    res = '0;
    for (int s = 0; s < NSEG; s++) begin
      dl = lat - grp(s, lat);
      res[s*SW +: SW] = rs[s];
      for (int d = 1; d <= MAX_PIPES; d++)
        if (dl == d) res[s*SW +: SW] = rd_q[s][d-1];
    end
  end

  always_comb begin
    out_valid = (lat == 0) & accept;
    for (int i = 1; i <= MAX_PIPES; i++)
      if (lat == i) out_valid = vq[i];
  end

  assign out        = out_valid ? res : '0;
  assign borrow_out = out_valid & ~co[NSEG-1];

`ifdef FINAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;

  // the top segment always sits in the last group, so its operands are delayed lat
  always_comb begin
    a_msb = in1[WIDTH-1];
    b_msb = in2[WIDTH-1];
    for (int d = 1; d <= MAX_PIPES; d++)
      if (lat == d) begin
        a_msb = sa_q[NSEG-1][d-1][SW-1];
        b_msb = sb_q[NSEG-1][d-1][SW-1];
      end
  end

  assign ovf = out_valid & (a_msb ^ b_msb) & (res[WIDTH-1] ^ a_msb);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg  <= '0;
      vq   <= '0;
      cr_q <= '0;
      for (int s = 0; s < NSEG; s++)
        for (int d = 0; d < MAX_PIPES; d++) begin
          sa_q[s][d] <= '0;
          sb_q[s][d] <= '0;
          rd_q[s][d] <= '0;
        end
    end else begin
      if (!busy && !in_ready) cfg <= want;
      vq[1] <= accept & (lat >= 1);
      for (int i = 2; i <= MAX_PIPES; i++)
        vq[i] <= vq[i-1] & (i <= lat);
      cr_q <= {co[NSEG-2:0], 1'b1};
      for (int s = 0; s < NSEG; s++) begin
        sa_q[s][0] <= in1[s*SW +: SW];
        sb_q[s][0] <= in2[s*SW +: SW];
        rd_q[s][0] <= rs[s];
        for (int d = 1; d < MAX_PIPES; d++) begin
          sa_q[s][d] <= sa_q[s][d-1];
          sb_q[s][d] <= sb_q[s][d-1];
          rd_q[s][d] <= rd_q[s][d-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_final_subtraction.sv
// Scoreboard bench for final_subtraction: directed steps, queue of expected results.
// Checks value, borrow, latency, handshake and reset behaviour.
module tb_final_subtraction;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pipes;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic [15:0] out;
  logic        borrow_out;
  logic        busy;
`ifdef FINAL_SUB_OVERFLOW_EN
  logic        ovf;
`endif

  final_subtraction dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipes     (pipes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out       (out),
    .borrow_out(borrow_out),
    .busy      (busy)
`ifdef FINAL_SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        v;
    int          c;
    int          l;
  } exp_t;

  exp_t q[$];
  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int exp_lat = 0;

  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input int c, input int l);
    exp_t e;
    e.d = a - b;
    e.b = (a < b);
    e.v = (a[15] != b[15]) && (e.d[15] != a[15]);
    e.c = c;
    e.l = l;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_valid: out_valid=1 out=%h, expected no result", out);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (out === e.d) else begin
          errors++;
          $error("FAIL out: got %h expected %h", out, e.d);
        end
        checks++;
        assert (borrow_out === e.b) else begin
          errors++;
          $error("FAIL borrow: got %b expected %b", borrow_out, e.b);
        end
        checks++;
        assert (cyc - e.c == e.l) else begin
          errors++;
          $error("FAIL latency: got %0d expected %0d", cyc - e.c, e.l);
        end
`ifdef FINAL_SUB_OVERFLOW_EN
        checks++;
        assert (ovf === e.v) else begin
          errors++;
          $error("FAIL ovf: got %b expected %b", ovf, e.v);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    #1;
    if (in_ready) q.push_back(model(a, b, cyc, exp_lat));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    q.delete();
  endtask

  task automatic reconfig(input logic [2:0] p);
    int n;
    n = 0;
    pipes = p;
    in_valid = 1'b0;
    #1;
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++;
      $error("FAIL reconfig_ready_drop: in_ready=%b expected 0", in_ready);
    end
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (n == 1) else begin
      errors++;
      $error("FAIL reconfig_wait: %0d cycles expected 1", n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pipes = 3'd0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (2) tick();
    checks++;
    assert ({out_valid, busy, borrow_out} === 3'b000 && out === 16'h0) else begin
      errors++;
      $error("FAIL reset_state: ov=%b busy=%b borrow=%b out=%h expected 0", out_valid, busy, borrow_out, out);
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
    rst_n = 1'b1;
    tick();

    exp_lat = 0;
    in_valid = 1'b1;
    in1 = 16'd10350;
    in2 = 16'd2500;
    #1;
    checks++;
    assert (out_valid === 1'b1 && out === 16'd7850 && borrow_out === 1'b0) else begin
      errors++;
      $error("FAIL comb_l0: ov=%b out=%0d borrow=%b expected 1 7850 0", out_valid, out, borrow_out);
    end
    q.push_back(model(16'd10350, 16'd2500, cyc, exp_lat));
    @(posedge clk);
    #1;
    drive(16'h0000, 16'h0001);
    drive(16'h1234, 16'h1234);
    drive(16'h8000, 16'h0001);
    drive(16'hFFFF, 16'h0000);
    drain();

    reconfig(3'd2);
    exp_lat = 2;
    drive(16'd1, 16'd2);
    drain();

    reconfig(3'd4);
    exp_lat = 4;
    repeat (50) drive(16'($urandom), 16'($urandom));
    drain();

    reconfig(3'd1);
    exp_lat = 1;
    repeat (6) drive(16'($urandom), 16'($urandom));
    pipes = 3'd3;
    in_valid = 1'b1;
    in1 = 16'h4444;
    in2 = 16'h5555;
    #1;
    checks++;
    assert (in_ready === 1'b0 && busy === 1'b1) else begin
      errors++;
      $error("FAIL midcfg_drop: in_ready=%b busy=%b expected 0 1", in_ready, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (in_ready === 1'b0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL midcfg_drained: in_ready=%b busy=%b expected 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL midcfg_ready: in_ready=%b expected 1", in_ready);
    end
    exp_lat = 3;
    repeat (5) drive(16'($urandom), 16'($urandom));
    drain();

    reconfig(3'd5);
    exp_lat = 4;
    repeat (4) drive(16'($urandom), 16'($urandom));
    drain();

    repeat (3) drive(16'($urandom), 16'($urandom));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (out_valid === 1'b0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL async_reset: ov=%b busy=%b expected 0 0", out_valid, busy);
    end
    q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++;
      $error("FAIL reset_cfg: in_ready=%b expected 0 with pipes=5", in_ready);
    end
    pipes = 3'd0;
    #1;
    checks++;
    assert (in_ready === 1'b1 && out === 16'h0) else begin
      errors++;
      $error("FAIL reset_cfg0: in_ready=%b out=%h expected 1 0000", in_ready, out);
    end
    repeat (6) tick();

    exp_lat = 0;
    drive(16'h8000, 16'h0001);
    drive(16'h0000, 16'h0001);
    drive(16'h7FFF, 16'hFFFF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
